fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 97 +++++++++
 tb/tb_fifo_uart_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one byte per frame from a FIFO read port.
// Frame is start, 8 data bits LSB first, optional even parity, then stop.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt, rd_en_nxt;
  logic          last;

  assign last       = (cnt == LAST);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && last;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    case (state)
      IDLE:   if (!empty) state_nxt = LOAD;
      LOAD: begin
        state_nxt = START;
        shreg_nxt = rd_data;
        bit_nxt   = '0;
      end
      START: begin
        if (last) state_nxt = DATA;
        else      cnt_nxt   = cnt + CW'(1);
      end
      DATA: begin
        if (last) begin
          // Rotate so the captured byte is intact again for the parity bit.
          shreg_nxt = {shreg[0], shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (last) state_nxt = STOP;
        else      cnt_nxt   = cnt + CW'(1);
      end
      STOP: begin
        if (last) state_nxt = IDLE;
        else      cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase

    rd_en_nxt = (state_nxt == LOAD);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = ^shreg_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= 8'h00;
      tx      <= 1'b1;
      rd_en   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
      rd_en   <= rd_en_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) each fed by a small FIFO model.
// Expected line activity is generated per cycle from the frame format.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem [2][256];
  logic [7:0] wptr [2];
  logic [7:0] rptr [2];
  logic       ovr_en [2];
  logic       ovr_val [2];
  logic       empty_w [2];
  logic [7:0] rd_data_w [2];
  logic       rd_en_w [2];
  logic       tx_w [2];
  logic       busy_w [2];
  logic       fd_w [2];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] byte_q [$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .empty(empty_w[0]), .rd_data(rd_data_w[0]),
    .rd_en(rd_en_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .empty(empty_w[1]), .rd_data(rd_data_w[1]),
    .rd_en(rd_en_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  // FIFO read side: data shown at the read pointer, pointer advances on a pop.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      empty_w[d]   = ovr_en[d] ? ovr_val[d] : (wptr[d] == rptr[d]);
      rd_data_w[d] = mem[d][rptr[d]];
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rd_en_w[d]) rptr[d] <= rptr[d] + 8'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input int d, input string tag, input int etx, input int erd,
                          input int ebusy, input int efd);
    chk($sformatf("%s.d%0d.tx", tag, d), int'(tx_w[d]), etx);
    chk($sformatf("%s.d%0d.rd_en", tag, d), int'(rd_en_w[d]), erd);
    chk($sformatf("%s.d%0d.busy", tag, d), int'(busy_w[d]), ebusy);
    chk($sformatf("%s.d%0d.frame_done", tag, d), int'(fd_w[d]), efd);
  endtask

  // Line level of serial bit slot idx of a frame carrying b.
  function automatic int exp_bit(input logic [7:0] b, input int idx, input int par);
    if (idx == 0) return 0;
    if (idx <= 8) return int'(b[idx-1]);
    if (idx == 9 && par != 0) return int'(^b);
    return 1;
  endfunction

  // Pushes byte_q into FIFO d, then checks every cycle of the back-to-back frames.
  task automatic run_burst(input int d, input int toggle);
    int nb = 10 + d;
    int n;
    logic [7:0] b;
    logic [7:0] start_ptr;
    @(negedge clk);
    start_ptr = rptr[d];
    n = byte_q.size();
    for (int i = 0; i < n; i++) begin
      mem[d][wptr[d]] = byte_q[i];
      wptr[d] = wptr[d] + 8'd1;
    end
    for (int f = 0; f < n; f++) begin
      b = byte_q[f];
      chk_outs(d, $sformatf("idle%0d", f), 1, 0, 0, 0);
      @(negedge clk);
      chk_outs(d, $sformatf("load%0d", f), 1, 1, 1, 0);
      @(negedge clk);
      for (int k = 0; k < nb*C; k++) begin
        chk_outs(d, $sformatf("f%0d.c%0d", f, k), exp_bit(b, k/C, d), 0, 1,
                 (k == nb*C-1) ? 1 : 0);
        if (toggle != 0 && k >= C && k < 9*C) begin
          ovr_en[d]  = 1'b1;
          ovr_val[d] = 1'($urandom_range(0, 1));
        end else begin
          ovr_en[d] = 1'b0;
        end
        @(negedge clk);
      end
    end
    chk_outs(d, "after", 1, 0, 0, 0);
    chk($sformatf("pops.d%0d", d), int'(rptr[d] - start_ptr), n);
    byte_q.delete();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      wptr[d] = '0; rptr[d] = '0; ovr_en[d] = 1'b0; ovr_val[d] = 1'b1;
      for (int i = 0; i < 256; i++) mem[d][i] = '0;
    end
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk_outs(d, "reset", 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Empty held high: line stays idle.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk_outs(d, $sformatf("quiet%0d", c), 1, 0, 0, 0);
    end

    byte_q = '{8'hA5};                    run_burst(0, 0);
    byte_q = '{8'h07};                    run_burst(1, 0);
    byte_q = '{8'h00, 8'hFF, 8'h3C};      run_burst(0, 0);
    byte_q = '{8'h00, 8'hFF, 8'h3C};      run_burst(1, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) byte_q.push_back(8'($urandom));
      run_burst(r % 2, 0);
    end
    byte_q = '{8'($urandom)};             run_burst(0, 1);
    byte_q = '{8'($urandom)};             run_burst(1, 1);

    // Abort in the 5th data bit.
    begin
      logic [7:0] ptr_after;
      @(negedge clk);
      mem[0][wptr[0]] = 8'($urandom);
      wptr[0] = wptr[0] + 8'd1;
      repeat (2 + C + 4*C + 2) @(negedge clk);
      chk("abort.busy_before", int'(busy_w[0]), 1);
      rst = 1'b0;
      #1;
      chk_outs(0, "abort", 1, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      ptr_after = rptr[0];
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        chk_outs(0, $sformatf("post_abort%0d", c), 1, 0, 0, 0);
      end
      chk("abort.no_pop", int'(rptr[0]), int'(ptr_after));
      chk("abort.one_pop", int'(rptr[0]), int'(wptr[0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
